// File: rtl/map_pkg.sv
// map_pkg
// Shared definitions for the map room multiplexer: the room transition
// state type, default widths, named room indices and a default coordinate
// table that integrators can hand to map_room_mux through ROOM_XY.
package map_pkg;

  typedef enum logic [1:0] {
    LOOKUP = 2'd0,
    BLANK  = 2'd1,
    SHOW   = 2'd2
  } map_state_t;

  localparam int DEF_NUM_ROOMS = 12;
  localparam int DEF_COORD_W   = 4;
  localparam int DEF_COLOR_W   = 8;

  localparam logic [3:0] START_CASTLE     = 4'd0;
  localparam logic [3:0] HALLWAY_TOP      = 4'd1;
  localparam logic [3:0] HALLWAY_RIGHT    = 4'd2;
  localparam logic [3:0] HALLWAY_LEFT     = 4'd3;
  localparam logic [3:0] HALLWAY_BOTTOM   = 4'd4;
  localparam logic [3:0] BLUE_MAZE_TOP    = 4'd5;
  localparam logic [3:0] BLUE_MAZE_1      = 4'd6;
  localparam logic [3:0] BLUE_MAZE_BOTTOM = 4'd7;
  localparam logic [3:0] BLUE_MAZE_CENTER = 4'd8;
  localparam logic [3:0] BLUE_MAZE_ENTRY  = 4'd9;
  localparam logic [3:0] WHITE_CASTLE     = 4'd10;
  localparam logic [3:0] YELLOW_CASTLE    = 4'd11;

  // Entry i is {x, y} in byte i; entry 0 is the start castle at (3,5).
  localparam logic [DEF_NUM_ROOMS*2*DEF_COORD_W-1:0] DEFAULT_ROOM_XY =
    96'h43424140_14131211_10263635;

endpackage

// File: rtl/map_room_lookup.sv
// map_room_lookup
// Combinational priority encoder that maps a room coordinate pair to the
// index of the first matching entry of the coordinate table.
// Ports:
//   coord_x, coord_y : requested room column / row
//   idx              : lowest matching table index (0 when nothing matches)
//   hit              : a table entry matched
module map_room_lookup
  import map_pkg::*;
#(
  parameter int NUM_ROOMS = DEF_NUM_ROOMS,
  parameter int COORD_W   = DEF_COORD_W,
  parameter logic [NUM_ROOMS*2*COORD_W-1:0] ROOM_XY = '0
) (
  input  logic [COORD_W-1:0] coord_x,
  input  logic [COORD_W-1:0] coord_y,
  output logic [3:0]         idx,
  output logic               hit
);

  // Scan from the top entry down so that the lowest matching index is the
  // last one written and therefore wins.
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = NUM_ROOMS - 1; i >= 0; i--) begin
      if (ROOM_XY[i*2*COORD_W +: 2*COORD_W] == {coord_x, coord_y}) begin
        idx = 4'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/map_room_mux.sv
// map_room_mux
// Selects one room's pixel stream out of NUM_ROOMS room renderer outputs,
// chosen by looking the requested map coordinates up in ROOM_XY. A room
// change runs LOOKUP -> BLANK (BLANK_FRAMES frames) -> SHOW, with the
// picture held at BG_COLOR until SHOW. Pixels have a fixed two-cycle latency.
// Optional build macro: MAP_SCANLINE_FADE_EN shows the new room on odd rows
// while blanking.
// Ports:
//   clk_vga      : pixel clock
//   reset        : asynchronous, active-low reset
//   CurrentX/Y   : current pixel column / row
//   frame_start  : one-cycle pulse at the start of each frame
//   mapX, mapY   : requested room coordinates
//   room_pixels  : packed room colours, room i at [i*COLOR_W +: COLOR_W]
//   mapData      : selected pixel
//   room_idx     : index of the active room
//   room_valid   : active coordinates matched a table entry
//   room_changed : one-cycle pulse on entering SHOW
module map_room_mux
  import map_pkg::*;
#(
  parameter int NUM_ROOMS    = DEF_NUM_ROOMS,
  parameter int COORD_W      = DEF_COORD_W,
  parameter int COLOR_W      = DEF_COLOR_W,
  parameter logic [NUM_ROOMS*2*COORD_W-1:0] ROOM_XY = '0,
  parameter int BLANK_FRAMES = 1,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
  input  logic                         clk_vga,
  input  logic                         reset,
  input  logic [9:0]                   CurrentX,
  input  logic [8:0]                   CurrentY,
  input  logic                         frame_start,
  input  logic [COORD_W-1:0]           mapX,
  input  logic [COORD_W-1:0]           mapY,
  input  logic [NUM_ROOMS*COLOR_W-1:0] room_pixels,
  output logic [COLOR_W-1:0]           mapData,
  output logic [3:0]                   room_idx,
  output logic                         room_valid,
  output logic                         room_changed
);

  localparam logic [3:0] LAST_FRAME =
    (BLANK_FRAMES > 0) ? 4'(BLANK_FRAMES - 1) : 4'd0;

  map_state_t           state, next_state;
  logic [3:0]           blank_cnt, next_cnt;
  logic [COORD_W-1:0]   lat_x, lat_y;
  logic [3:0]           hit_idx;
  logic                 hit;
  logic                 coord_change;

  logic [COLOR_W-1:0]   stage1;
  map_state_t           state_d;
  logic                 valid_d;
  logic                 pass;
`ifdef MAP_SCANLINE_FADE_EN
  logic                 row_d;
`endif

  // The pixel position only matters for the optional fade row select.
  logic unused_pos;
  assign unused_pos = ^{CurrentX, CurrentY};

  map_room_lookup #(
    .NUM_ROOMS (NUM_ROOMS),
    .COORD_W   (COORD_W),
    .ROOM_XY   (ROOM_XY)
  ) u_lookup (
    .coord_x (mapX),
    .coord_y (mapY),
    .idx     (hit_idx),
    .hit     (hit)
  );

  assign coord_change = ({mapX, mapY} != {lat_x, lat_y});

  // Next-state logic. A coordinate change beats a frame_start arriving in
  // the same cycle, so blanking restarts from a fresh lookup.
  always_comb begin
    next_state = state;
    next_cnt   = blank_cnt;
    unique case (state)
      LOOKUP: begin
        next_cnt   = '0;
        next_state = (BLANK_FRAMES > 0) ? BLANK : SHOW;
      end
      BLANK: begin
        if (coord_change) begin
          next_state = LOOKUP;
        end else if (frame_start) begin
          next_cnt = blank_cnt + 4'd1;
          if (blank_cnt == LAST_FRAME) begin
            next_state = SHOW;
          end
        end
      end
      SHOW: begin
        if (coord_change) begin
          next_state = LOOKUP;
        end
      end
      default: next_state = LOOKUP;
    endcase
  end

  // State register plus the control outputs, which are captured from the
  // lookup only while in LOOKUP.
  always_ff @(posedge clk_vga or negedge reset) begin
    if (!reset) begin
      state        <= LOOKUP;
      blank_cnt    <= '0;
      lat_x        <= '0;
      lat_y        <= '0;
      room_idx     <= '0;
      room_valid   <= 1'b0;
      room_changed <= 1'b0;
    end else begin
      state        <= next_state;
      blank_cnt    <= next_cnt;
      room_changed <= (next_state == SHOW) && (state != SHOW);
      if (state == LOOKUP) begin
        lat_x      <= mapX;
        lat_y      <= mapY;
        room_idx   <= hit_idx;
        room_valid <= hit;
      end
    end
  end

  // Stage 2 gate, using control delayed alongside the stage 1 pixel.
  always_comb begin
    pass = (state_d == SHOW) && valid_d;
`ifdef MAP_SCANLINE_FADE_EN
    if ((state_d == BLANK) && valid_d && row_d) begin
      pass = 1'b1;
    end
`endif
  end

  // Two-stage pixel pipeline: select the room, then gate with the control
  // that was current when that pixel was selected.
  always_ff @(posedge clk_vga or negedge reset) begin
    if (!reset) begin
      stage1  <= '0;
      state_d <= LOOKUP;
      valid_d <= 1'b0;
      mapData <= BG_COLOR;
`ifdef MAP_SCANLINE_FADE_EN
      row_d   <= 1'b0;
`endif
    end else begin
      stage1  <= room_pixels[int'(room_idx)*COLOR_W +: COLOR_W];
      state_d <= state;
      valid_d <= room_valid;
      mapData <= pass ? stage1 : BG_COLOR;
`ifdef MAP_SCANLINE_FADE_EN
      row_d   <= CurrentY[0];
`endif
    end
  end

endmodule

// File: tb/tb_map_room_mux.sv
// tb_map_room_mux
// Two instances with different tables and blanking lengths share one set
// of inputs: dut_a (BLANK_FRAMES=1) and dut_b (BLANK_FRAMES=2, duplicate
// (3,5) entries at indices 4 and 7). A frame-counting reference model is
// compared every cycle, alongside directed sequences and a lookup table.
module tb_map_room_mux;

  localparam logic [95:0] TAB_A = 96'h43424140_14131211_10263635;
  localparam logic [95:0] TAB_B = 96'h53525150_35040335_02263601;
  localparam logic [7:0]  BG    = 8'h00;
`ifdef MAP_SCANLINE_FADE_EN
  localparam bit FADE = 1'b1;
`else
  localparam bit FADE = 1'b0;
`endif

  logic        clk_vga;
  logic        reset;
  logic [9:0]  CurrentX;
  logic [8:0]  CurrentY;
  logic        frame_start;
  logic [3:0]  mapX, mapY;
  logic [95:0] room_pixels;
  logic [7:0]  map_a, map_b;
  logic [3:0]  idx_a, idx_b;
  logic        valid_a, valid_b, chg_a, chg_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one slot per instance.
  logic [95:0] tabs [2];
  int          bf [2];
  bit          m_pending [2];
  logic [3:0]  m_lx [2], m_ly [2], m_idx [2];
  int          m_frames [2];
  bit          m_valid [2], m_chg [2], m_s1_ok [2];
  logic [7:0]  m_s1 [2], m_map [2];
  logic [7:0]  cand [12];

  map_room_mux #(
    .NUM_ROOMS(12), .COORD_W(4), .COLOR_W(8), .ROOM_XY(TAB_A),
    .BLANK_FRAMES(1), .BG_COLOR(8'h00)
  ) dut_a (
    .clk_vga(clk_vga), .reset(reset), .CurrentX(CurrentX), .CurrentY(CurrentY),
    .frame_start(frame_start), .mapX(mapX), .mapY(mapY),
    .room_pixels(room_pixels), .mapData(map_a), .room_idx(idx_a),
    .room_valid(valid_a), .room_changed(chg_a)
  );

  map_room_mux #(
    .NUM_ROOMS(12), .COORD_W(4), .COLOR_W(8), .ROOM_XY(TAB_B),
    .BLANK_FRAMES(2), .BG_COLOR(8'h00)
  ) dut_b (
    .clk_vga(clk_vga), .reset(reset), .CurrentX(CurrentX), .CurrentY(CurrentY),
    .frame_start(frame_start), .mapX(mapX), .mapY(mapY),
    .room_pixels(room_pixels), .mapData(map_b), .room_idx(idx_b),
    .room_valid(valid_b), .room_changed(chg_b)
  );

  initial clk_vga = 1'b0;
  always #5 clk_vga = ~clk_vga;

  typedef struct {
    logic [3:0] x, y;
    int idx_a, val_a, idx_b, val_b;
  } lookup_vec_t;

  lookup_vec_t vecs [10];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] x, input logic [3:0] y, input logic fs);
    mapX = x;
    mapY = y;
    frame_start = fs;
  endtask

  function automatic int pix(input int i);
    return 'hA0 + i;
  endfunction

  task automatic modelResetOne(input int d);
    m_pending[d] = 1'b1;
    m_lx[d] = '0; m_ly[d] = '0; m_idx[d] = '0;
    m_frames[d] = 0;
    m_valid[d] = 1'b0; m_chg[d] = 1'b0; m_s1_ok[d] = 1'b0;
    m_s1[d] = '0; m_map[d] = BG;
  endtask

  // The room shows once as many frame starts as the blanking length have
  // been seen since the coordinates were last looked up.
  task automatic modelStep();
    bit show_old, blank_old, show_new, hit;
    logic [3:0] fidx;
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        modelResetOne(d);
      end else begin
        show_old  = !m_pending[d] && (m_frames[d] >= bf[d]);
        blank_old = !m_pending[d] && (m_frames[d] < bf[d]);
        m_map[d]  = m_s1_ok[d] ? m_s1[d] : BG;
        m_s1[d]   = room_pixels[int'(m_idx[d])*8 +: 8];
        m_s1_ok[d] = m_valid[d] && (show_old || (FADE && blank_old && CurrentY[0]));
        if (m_pending[d]) begin
          hit = 1'b0;
          fidx = '0;
          for (int i = 0; i < 12; i++) begin
            if (!hit && tabs[d][i*8 +: 8] == {mapX, mapY}) begin
              hit = 1'b1;
              fidx = 4'(i);
            end
          end
          m_lx[d] = mapX; m_ly[d] = mapY;
          m_idx[d] = fidx; m_valid[d] = hit;
          m_frames[d] = 0;
          m_pending[d] = 1'b0;
        end else if ({mapX, mapY} != {m_lx[d], m_ly[d]}) begin
          m_pending[d] = 1'b1;
        end else if (blank_old && frame_start) begin
          m_frames[d]++;
        end
        show_new = !m_pending[d] && (m_frames[d] >= bf[d]);
        m_chg[d] = show_new && !show_old;
      end
    end
  endtask

  task automatic checkModel();
    checkOutput("model mapData a", int'(map_a), int'(m_map[0]));
    checkOutput("model room_idx a", int'(idx_a), int'(m_idx[0]));
    checkOutput("model room_valid a", int'(valid_a), int'(m_valid[0]));
    checkOutput("model room_changed a", int'(chg_a), int'(m_chg[0]));
    checkOutput("model mapData b", int'(map_b), int'(m_map[1]));
    checkOutput("model room_idx b", int'(idx_b), int'(m_idx[1]));
    checkOutput("model room_valid b", int'(valid_b), int'(m_valid[1]));
    checkOutput("model room_changed b", int'(chg_b), int'(m_chg[1]));
  endtask

  task automatic tick();
    @(posedge clk_vga);
    modelStep();
    #1;
    checkModel();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " mapData a"}, int'(map_a), 0);
    checkOutput({tag, " room_idx a"}, int'(idx_a), 0);
    checkOutput({tag, " room_valid a"}, int'(valid_a), 0);
    checkOutput({tag, " room_changed a"}, int'(chg_a), 0);
    checkOutput({tag, " mapData b"}, int'(map_b), 0);
    checkOutput({tag, " room_idx b"}, int'(idx_b), 0);
    checkOutput({tag, " room_valid b"}, int'(valid_b), 0);
    checkOutput({tag, " room_changed b"}, int'(chg_b), 0);
  endtask

  initial begin
    int cnt_a, cnt_b, bad_map;
    logic [7:0] c;

    tabs[0] = TAB_A; tabs[1] = TAB_B;
    bf[0] = 1; bf[1] = 2;
    modelResetOne(0);
    modelResetOne(1);
    cand[0] = 8'h35; cand[1] = 8'h36; cand[2] = 8'h26; cand[3] = 8'h10;
    cand[4] = 8'h14; cand[5] = 8'h43; cand[6] = 8'h01; cand[7] = 8'h04;
    cand[8] = 8'h53; cand[9] = 8'h99; cand[10] = 8'hFF; cand[11] = 8'h00;

    vecs[0] = '{4'd3, 4'd6, 1, 1, 1, 1};
    vecs[1] = '{4'd3, 4'd5, 0, 1, 4, 1};
    vecs[2] = '{4'd2, 4'd6, 2, 1, 2, 1};
    vecs[3] = '{4'd9, 4'd9, 0, 0, 0, 0};
    vecs[4] = '{4'd1, 4'd4, 7, 1, 0, 0};
    vecs[5] = '{4'd4, 4'd3, 11, 1, 0, 0};
    vecs[6] = '{4'd5, 4'd3, 0, 0, 11, 1};
    vecs[7] = '{4'd0, 4'd1, 0, 0, 0, 1};
    vecs[8] = '{4'd0, 4'd4, 0, 0, 6, 1};
    vecs[9] = '{4'd1, 4'd0, 3, 1, 0, 0};

    reset = 1'b0;
    CurrentX = '0;
    CurrentY = '0;
    for (int i = 0; i < 12; i++) room_pixels[i*8 +: 8] = 8'(pix(i));
    applyStimulus(4'd3, 4'd5, 1'b0);
    #1;
    checkResetValues("reset");
    tick();
    tick();
    reset = 1'b1;

    $display("[TB] first lookup and show after reset");
    tick();
    checkOutput("lookup idx a", int'(idx_a), 0);
    checkOutput("lookup valid a", int'(valid_a), 1);
    checkOutput("duplicate idx b", int'(idx_b), 4);
    checkOutput("lookup valid b", int'(valid_b), 1);
    checkOutput("no change during blank a", int'(chg_a), 0);
    applyStimulus(4'd3, 4'd5, 1'b1);
    tick();
    applyStimulus(4'd3, 4'd5, 1'b0);
    checkOutput("enter show pulse a", int'(chg_a), 1);
    checkOutput("still blanking b", int'(chg_b), 0);
    tick();
    checkOutput("pulse ends a", int'(chg_a), 0);
    checkOutput("pixel latency 1 a", int'(map_a), 0);
    tick();
    checkOutput("pixel latency 2 a", int'(map_a), pix(0));

    $display("[TB] switch to room (3,6)");
    applyStimulus(4'd3, 4'd6, 1'b0);
    tick();
    tick();
    checkOutput("switch idx a", int'(idx_a), 1);
    checkOutput("switch idx b", int'(idx_b), 1);
    applyStimulus(4'd3, 4'd6, 1'b1);
    tick();
    applyStimulus(4'd3, 4'd6, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("blank two frames b", int'(map_b), 0);
      tick();
    end
    applyStimulus(4'd3, 4'd6, 1'b1);
    tick();
    applyStimulus(4'd3, 4'd6, 1'b0);
    checkOutput("second frame pulse b", int'(chg_b), 1);
    checkOutput("second frame bg b", int'(map_b), 0);
    tick();
    checkOutput("latency bg b", int'(map_b), 0);
    tick();
    checkOutput("room 1 pixel b", int'(map_b), pix(1));
    checkOutput("room 1 pixel a", int'(map_a), pix(1));

    $display("[TB] unmapped coordinates");
    applyStimulus(4'd9, 4'd9, 1'b0);
    tick();
    tick();
    checkOutput("unmapped idx a", int'(idx_a), 0);
    checkOutput("unmapped valid a", int'(valid_a), 0);
    checkOutput("unmapped idx b", int'(idx_b), 0);
    checkOutput("unmapped valid b", int'(valid_b), 0);
    cnt_a = 0; cnt_b = 0; bad_map = 0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        applyStimulus(4'd9, 4'd9, (k == 0));
        tick();
        if (chg_a) cnt_a++;
        if (chg_b) cnt_b++;
        if (map_a != BG || map_b != BG) bad_map++;
      end
    end
    applyStimulus(4'd9, 4'd9, 1'b0);
    checkOutput("unmapped pulses a", cnt_a, 1);
    checkOutput("unmapped pulses b", cnt_b, 1);
    checkOutput("unmapped non-bg pixels", bad_map, 0);

    $display("[TB] change on final blanking frame");
    applyStimulus(4'd3, 4'd5, 1'b0);
    tick();
    tick();
    applyStimulus(4'd3, 4'd5, 1'b1);
    tick();
    applyStimulus(4'd3, 4'd5, 1'b0);
    tick();
    tick();
    applyStimulus(4'd2, 4'd6, 1'b1);
    tick();
    applyStimulus(4'd2, 4'd6, 1'b0);
    checkOutput("change wins over show b", int'(chg_b), 0);
    checkOutput("idx held before lookup b", int'(idx_b), 4);
    tick();
    checkOutput("relookup idx b", int'(idx_b), 2);
    applyStimulus(4'd2, 4'd6, 1'b1);
    tick();
    applyStimulus(4'd2, 4'd6, 1'b0);
    checkOutput("restarted count b", int'(chg_b), 0);
    tick();
    tick();
    applyStimulus(4'd2, 4'd6, 1'b1);
    tick();
    applyStimulus(4'd2, 4'd6, 1'b0);
    checkOutput("show after restart b", int'(chg_b), 1);

    $display("[TB] blanking rows and reset mid-blank");
    applyStimulus(4'd3, 4'd5, 1'b0);
    tick();
    tick();
    CurrentY = 9'd1;
    tick(); tick(); tick();
    checkOutput("odd row blank a", int'(map_a), FADE ? pix(0) : 0);
    checkOutput("odd row blank b", int'(map_b), FADE ? pix(4) : 0);
    CurrentY = 9'd2;
    tick(); tick(); tick();
    checkOutput("even row blank a", int'(map_a), 0);
    checkOutput("even row blank b", int'(map_b), 0);
    #2;
    reset = 1'b0;
    #1;
    checkResetValues("async reset");
    modelResetOne(0);
    modelResetOne(1);
    tick();
    reset = 1'b1;

    $display("[TB] lookup vectors");
    foreach (vecs[v]) begin
      applyStimulus(vecs[v].x, vecs[v].y, 1'b0);
      tick();
      tick();
      checkOutput($sformatf("vec%0d idx a", v), int'(idx_a), vecs[v].idx_a);
      checkOutput($sformatf("vec%0d valid a", v), int'(valid_a), vecs[v].val_a);
      checkOutput($sformatf("vec%0d idx b", v), int'(idx_b), vecs[v].idx_b);
      checkOutput($sformatf("vec%0d valid b", v), int'(valid_b), vecs[v].val_b);
    end

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(39, 0) == 0) begin
        c = cand[$urandom_range(11, 0)];
        mapX = c[7:4];
        mapY = c[3:0];
      end
      frame_start = ($urandom_range(5, 0) == 0);
      CurrentX = 10'($urandom);
      CurrentY = 9'($urandom);
      room_pixels = {$urandom, $urandom, $urandom};
      if (!reset) reset = 1'b1;
      else if ($urandom_range(499, 0) == 0) reset = 1'b0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
